// File: rtl/tlul_masked_byte_sequencer.sv
// Serialises one masked data beat into a byte stream, lowest enabled lane first.
// A zero-mask beat produces no bytes, only a DONE pulse.
module tlul_masked_byte_sequencer #(
    parameter int W        = 8,
    parameter int BYTE_BIT = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_in_valid,
    output logic                    o_in_ready,
    input  logic [W*BYTE_BIT-1:0]   i_in_data,
    input  logic [W-1:0]            i_in_mask,
    output logic                    o_out_valid,
    input  logic                    i_out_ready,
    output logic [BYTE_BIT-1:0]     o_out_byte,
    output logic                    o_out_last,
    output logic [$clog2(W+1)-1:0]  o_beat_bytes,
    output logic                    o_done
);

    localparam int CW = $clog2(W+1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [0:0]            r_state;
    logic [W*BYTE_BIT-1:0] r_data;
    logic [W-1:0]          r_rem_mask;
    logic [CW-1:0]         r_beat_bytes;
    logic                  r_done;
    logic                  r_zero_pend;

    logic [BYTE_BIT-1:0]   w_sel_byte;
    logic [W-1:0]          w_rem_next;
    logic                  w_single;
    logic                  w_send;
    logic                  w_in_hs;
    logic                  w_out_hs;
    logic [CW-1:0]         w_pop;

    // Descending scan so the lowest set lane wins.
    always_comb begin
        w_sel_byte = '0;
        for (int i = W-1; i >= 0; i--) begin
            if (r_rem_mask[i]) begin
                w_sel_byte = r_data[i*BYTE_BIT +: BYTE_BIT];
            end
        end
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < W; i++) begin
            w_pop = w_pop + CW'(i_in_mask[i]);
        end
    end

    assign w_rem_next   = r_rem_mask & (r_rem_mask - W'(1));
    assign w_single     = (r_rem_mask != '0) && (w_rem_next == '0);
    assign w_send       = (r_state == ST_SEND);

    assign o_out_valid  = w_send;
    assign o_out_byte   = w_send ? w_sel_byte : '0;
    assign o_out_last   = w_send & w_single;
    assign o_in_ready   = ~w_send | (i_out_ready & o_out_last);
    assign o_beat_bytes = r_beat_bytes;
    assign o_done       = r_done;

    assign w_in_hs      = i_in_valid & o_in_ready;
    assign w_out_hs     = o_out_valid & i_out_ready;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_data       <= '0;
            r_rem_mask   <= '0;
            r_beat_bytes <= '0;
            r_done       <= 1'b0;
            r_zero_pend  <= 1'b0;
        end else begin
            r_done      <= r_zero_pend;
            r_zero_pend <= 1'b0;
            if (w_out_hs) begin
                r_rem_mask <= w_rem_next;
                if (o_out_last) begin
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end
            end
            if (w_in_hs) begin
                r_beat_bytes <= w_pop;
                if (i_in_mask != '0) begin
                    r_data     <= i_in_data;
                    r_rem_mask <= i_in_mask;
                    r_state    <= ST_SEND;
                end else if (w_send) begin
                    // Last-byte DONE goes out first; the empty beat's DONE follows.
                    r_zero_pend <= 1'b1;
                end else begin
                    r_done <= 1'b1;
                end
            end
        end
    end

endmodule
